// File: rtl/de_pipe_reg_pkg.sv
// de_pipe_reg_pkg: shared pipeline constants, stage-register control encoding and helpers.
package de_pipe_reg_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int          TNEW_W_DEF   = 2;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [4:0]  NO_DEST      = 5'd0;
  typedef enum logic [1:0] {
    SEL_RESET,
    SEL_HOLD,
    SEL_BUBBLE,
    SEL_LOAD
  } de_sel_e;
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/de_pipe_reg_field.sv
// pipe_field_reg: one pipeline register field with sync active-low reset and hold > clear > load priority.
module pipe_field_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             hold_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] data_q, data_d;
  always_comb begin
    data_d = hold_i ? data_q : clear_i ? CLEAR_VAL : load_i ? d_i : data_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) data_q <= RESET_VAL;
    else         data_q <= data_d;
  end
  assign q_o = data_q;
endmodule

// File: rtl/de_pipe_reg.sv
// de_pipe_reg: D->E pipeline register with hold/flush/stall bubbles and Tnew decrement.
// Optional bubble counter output E_BubbleCnt is enabled by defining DE_BUBBLE_COUNT_EN.
module de_pipe_reg
  import de_pipe_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          TNEW_W   = TNEW_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              hold,
  input  logic              flush,
  input  logic              stall,
  input  logic [31:0]       D_PC,
  input  logic [31:0]       D_Instr,
  input  logic [31:0]       D_RSData,
  input  logic [31:0]       D_RTData,
  input  logic [31:0]       D_ExtResult,
  input  logic [4:0]        D_WriteReg,
  input  logic [TNEW_W-1:0] D_Tnew,
  input  logic              D_valid,
  output logic [31:0]       E_PC,
  output logic [31:0]       E_Instr,
  output logic [31:0]       E_RSData,
  output logic [31:0]       E_RTData,
  output logic [31:0]       E_ExtResult,
  output logic [4:0]        E_WriteReg,
  output logic [TNEW_W-1:0] E_Tnew,
  output logic              E_valid
`ifdef DE_BUBBLE_COUNT_EN
  ,
  output logic [31:0]       E_BubbleCnt
`endif
);
  de_sel_e           sel;
  logic              frz, bub, ld, kill_dst;
  logic [TNEW_W-1:0] tnew_d;
  always_comb begin
    sel      = !resetn ? SEL_RESET : hold ? SEL_HOLD : (flush || stall) ? SEL_BUBBLE : SEL_LOAD;
    frz      = (sel == SEL_HOLD);
    bub      = (sel == SEL_BUBBLE);
    ld       = (sel == SEL_LOAD);
    kill_dst = bub || !D_valid;
    tnew_d   = (D_Tnew == '0) ? '0 : D_Tnew - 1'b1;
  end
  // PC is never cleared: a bubble carries the D-stage PC forward
  pipe_field_reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .resetn(resetn), .hold_i(frz), .clear_i(1'b0), .load_i(ld || bub),
    .d_i(D_PC), .q_o(E_PC)
  );
  pipe_field_reg #(.WIDTH(32), .RESET_VAL(NOP_INSTR), .CLEAR_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .resetn(resetn), .hold_i(frz), .clear_i(bub), .load_i(ld),
    .d_i(D_Instr), .q_o(E_Instr)
  );
  pipe_field_reg #(.WIDTH(32)) u_rs (
    .clk(clk), .resetn(resetn), .hold_i(frz), .clear_i(bub), .load_i(ld),
    .d_i(D_RSData), .q_o(E_RSData)
  );
  pipe_field_reg #(.WIDTH(32)) u_rt (
    .clk(clk), .resetn(resetn), .hold_i(frz), .clear_i(bub), .load_i(ld),
    .d_i(D_RTData), .q_o(E_RTData)
  );
  pipe_field_reg #(.WIDTH(32)) u_ext (
    .clk(clk), .resetn(resetn), .hold_i(frz), .clear_i(bub), .load_i(ld),
    .d_i(D_ExtResult), .q_o(E_ExtResult)
  );
  pipe_field_reg #(.WIDTH(5), .RESET_VAL(NO_DEST), .CLEAR_VAL(NO_DEST)) u_wr (
    .clk(clk), .resetn(resetn), .hold_i(frz), .clear_i(kill_dst), .load_i(ld),
    .d_i(D_WriteReg), .q_o(E_WriteReg)
  );
  pipe_field_reg #(.WIDTH(TNEW_W)) u_tnew (
    .clk(clk), .resetn(resetn), .hold_i(frz), .clear_i(kill_dst), .load_i(ld),
    .d_i(tnew_d), .q_o(E_Tnew)
  );
  pipe_field_reg #(.WIDTH(1)) u_valid (
    .clk(clk), .resetn(resetn), .hold_i(frz), .clear_i(bub), .load_i(ld),
    .d_i(D_valid), .q_o(E_valid)
  );
`ifdef DE_BUBBLE_COUNT_EN
  logic [31:0] bub_cnt_q, bub_cnt_d;
  always_comb begin
    bub_cnt_d = bub ? sat_inc32(bub_cnt_q) : bub_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) bub_cnt_q <= '0;
    else         bub_cnt_q <= bub_cnt_d;
  end
  assign E_BubbleCnt = bub_cnt_q;
`endif
endmodule

// File: doc/de_pipe_reg.md
DE_PIPE_REG -- requirements
Module: de_pipe_reg

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning PC value driven on E_PC after reset and carried by reset bubbles.
REQ-002 SHALL have parameter TNEW_W, default 2, meaning width of Tnew fields.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port hold  input  1  E stage busy (multi-cycle op); freeze register.
REQ-006 SHALL have port flush  input  1  kill the D-stage instruction; insert bubble.
REQ-007 SHALL have port stall  input  1  D-stage data hazard; insert bubble.
REQ-008 SHALL have ports D_PC, D_Instr, D_RSData, D_RTData, D_ExtResult  input  32 each  D-stage values; D_ExtResult is the 32-bit sign/zero-extended immediate from the D-stage extender.
REQ-009 SHALL have port D_WriteReg  input  5  destination GPR, 0 = none.
REQ-010 SHALL have port D_Tnew  input  TNEW_W  cycles until result ready, counted from D.
REQ-011 SHALL have port D_valid  input  1  D holds a real instruction.
REQ-012 SHALL have outputs E_PC, E_Instr, E_RSData, E_RTData, E_ExtResult (32 each), E_WriteReg (5), E_Tnew (TNEW_W), E_valid (1): registered E-stage copies.
REQ-013 SHALL have output E_BubbleCnt  32  bubble count, present only under DE_BUBBLE_COUNT_EN.

Function
REQ-014 SHALL select per cycle with priority: reset > hold > flush > stall > load.
REQ-015 SHALL, on hold, keep every output unchanged, including E_Tnew.
REQ-016 SHALL, on flush or stall (hold low), insert a bubble: E_Instr, E_RSData, E_RTData, E_ExtResult = 0, E_WriteReg = 0, E_Tnew = 0, E_valid = 0, E_PC = D_PC.
REQ-017 SHALL, on load, capture all D_* fields with latency one cycle, except Tnew.
REQ-018 SHALL compute E_Tnew on load as D_Tnew-1, saturating at 0 (D_Tnew = 0 gives 0).
REQ-019 SHALL, on load with D_valid = 0, force E_WriteReg = 0 and E_Tnew = 0 and leave the other fields captured.
REQ-020 SHALL, when hold and flush are both high, discard the flush; the upstream hazard unit keeps D frozen and re-asserts it.
REQ-021 SHALL have no combinational path from any input to any output.

Reset
REQ-022 SHALL, when resetn = 0 at a rising edge, set E_PC = RESET_PC, all other outputs 0, and E_BubbleCnt = 0, overriding hold, flush and stall.
REQ-023 SHALL resume normal loading on the first edge with resetn = 1; reset during hold SHALL clear the frozen contents.

Configuration
REQ-024 SHALL, with DE_BUBBLE_COUNT_EN defined, increment E_BubbleCnt by 1 on every cycle where REQ-016 applies; it SHALL saturate at 32'hFFFF_FFFF and SHALL NOT change on hold or load.
REQ-025 SHALL, without DE_BUBBLE_COUNT_EN, omit the E_BubbleCnt port and its counter, with all other behaviour identical.

Structure
REQ-026 SHALL take RESET_PC default, TNEW_W default and the bubble encodings (NOP = 32'h0, no-destination = 5'd0) from the shared pipeline constants package used by all stage registers.
REQ-027 SHALL build each field from one sub-module, pipe_field_reg (parameter WIDTH, RESET_VAL; controls hold/clear/load), instantiated once per field.

Verification
REQ-028 SHALL cover load: D_PC=32'h3004, D_Instr=32'h3421_0005, D_ExtResult=32'h0000_0005, D_WriteReg=1, D_Tnew=2, D_valid=1 -> next cycle all E_* equal these values, with E_Tnew=1 and E_valid=1.
REQ-029 SHALL cover stall: stall=1 with D_PC=32'h3008 -> E_Instr=0, E_WriteReg=0, E_valid=0, E_PC=32'h3008, E_BubbleCnt +1 when the macro is defined.
REQ-030 SHALL cover hold vs flush: hold=1 and flush=1 for 3 cycles after a load -> outputs unchanged for all 3 cycles, E_BubbleCnt unchanged.
REQ-031 SHALL cover Tnew saturation: load with D_Tnew=0, D_valid=1 -> E_Tnew=0; load with D_valid=0 and D_WriteReg=5 -> E_WriteReg=0.
REQ-032 SHALL cover reset mid-hold: hold=1 and resetn=0 at one edge -> E_PC=32'h0000_3000, other outputs 0, E_BubbleCnt=0.
REQ-033 SHALL cover counter saturation (macro defined): force counter to 32'hFFFF_FFFE, then 3 stall cycles -> E_BubbleCnt=32'hFFFF_FFFF.
